// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

  // Loader control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } ccff_state_t;

  // Bits needed to hold a count from 0 up to and including max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_word_shifter.sv
// Single-word buffer that serialises a bitstream word LSB first and
// tracks how many unshifted bits it still holds.
module ccff_word_shifter
  import ccff_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic                     clk_pad,
  input  logic                     pReset_pad,
  input  logic                     clear,
  input  logic                     load,
  input  logic [WORD_W-1:0]        load_data,
  input  logic                     shift,
  output logic                     lsb,
  output logic [cnt_w(WORD_W)-1:0] count,
  output logic                     empty
);

  localparam int SC_W = cnt_w(WORD_W);
  localparam logic [SC_W-1:0] FULL_WORD = SC_W'(WORD_W);

  logic [WORD_W-1:0] data_reg;
  logic [SC_W-1:0]   cnt_reg;

  // Clear beats load beats shift; a load in the cycle the last bit shifts
  // out simply replaces the spent word, which keeps the stream bubble-free.
  always_ff @(posedge clk_pad or posedge pReset_pad) begin
    if (pReset_pad) begin
      data_reg <= '0;
      cnt_reg  <= '0;
    end else if (clear) begin
      data_reg <= '0;
      cnt_reg  <= '0;
    end else if (load) begin
      data_reg <= load_data;
      cnt_reg  <= FULL_WORD;
    end else if (shift && (cnt_reg != '0)) begin
      data_reg <= data_reg >> 1;
      cnt_reg  <= cnt_reg - 1'b1;
    end
  end

  assign lsb   = data_reg[0];
  assign count = cnt_reg;
  assign empty = (cnt_reg == '0);

endmodule

// File: rtl/ccff_loader.sv
// Streams a word-wide bitstream serially into a configuration flip-flop
// chain, gating the programming clock to exactly the bit-carrying cycles.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk_pad,
  input  logic                        pReset_pad,
  input  logic                        start,
  input  logic                        abort,
  input  logic [WORD_W-1:0]           bs_data,
  input  logic                        bs_valid,
  output logic                        bs_ready,
  output logic                        ccff_head_pad,
  output logic                        prog_clk_en,
  output logic                        config_done,
  output logic                        busy,
  output logic                        error,
  output logic [cnt_w(CHAIN_LEN)-1:0] bit_count
);

  localparam int CNT_W  = cnt_w(CHAIN_LEN);
  localparam int SC_W   = cnt_w(WORD_W);
  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int WC_W   = cnt_w(NWORDS);
  localparam int TO_W   = cnt_w(TIMEOUT);

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_BITS = CNT_W'(CHAIN_LEN);
  localparam logic [WC_W-1:0]  WORDS_MAX = WC_W'(NWORDS);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [SC_W-1:0]  ONE_BIT   = SC_W'(1);

  ccff_state_t      state_reg, state_next;
  logic [CNT_W-1:0] bit_count_reg;
  logic [WC_W-1:0]  words_reg;
  logic [TO_W-1:0]  timeout_reg;

  logic             sh_lsb;
  logic [SC_W-1:0]  sh_count;
  logic             sh_empty;

  logic in_load, shift_en, ready, xfer, last_shift, starve, timeout_hit;
  logic start_load, sh_clear;

  assign in_load     = (state_reg == ST_LOAD);
  assign shift_en    = in_load && !sh_empty;
  // A new word fits when the buffer is empty or its final bit leaves now;
  // words past the chain length are never requested.
  assign ready       = in_load && (sh_empty || (sh_count == ONE_BIT)) &&
                       (words_reg < WORDS_MAX);
  assign xfer        = ready && bs_valid;
  assign last_shift  = shift_en && (bit_count_reg == LAST_BIT);
  assign starve      = in_load && sh_empty && !xfer;
  assign timeout_hit = starve && (timeout_reg == TO_LAST);
  assign start_load  = start && !abort && !in_load;
  // Completing the chain drops any leftover bits of a partial last word.
  assign sh_clear    = abort || start_load || last_shift;

  ccff_word_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk_pad    (clk_pad),
    .pReset_pad (pReset_pad),
    .clear      (sh_clear),
    .load       (xfer),
    .load_data  (bs_data),
    .shift      (shift_en),
    .lsb        (sh_lsb),
    .count      (sh_count),
    .empty      (sh_empty)
  );

  // State register.
  always_ff @(posedge clk_pad or posedge pReset_pad) begin
    if (pReset_pad) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: abort dominates, start is ignored while loading.
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) state_next = ST_LOAD;
        end
        ST_LOAD: begin
          if (last_shift)       state_next = ST_DONE;
          else if (timeout_hit) state_next = ST_ERROR;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Bit, word and starvation counters; all restart when a load begins.
  always_ff @(posedge clk_pad or posedge pReset_pad) begin
    if (pReset_pad) begin
      bit_count_reg <= '0;
      words_reg     <= '0;
      timeout_reg   <= '0;
    end else if (start_load) begin
      bit_count_reg <= '0;
      words_reg     <= '0;
      timeout_reg   <= '0;
    end else begin
      if (shift_en && (bit_count_reg != FULL_BITS)) begin
        bit_count_reg <= bit_count_reg + 1'b1;
      end
      if (abort) begin
        words_reg   <= '0;
        timeout_reg <= '0;
      end else if (in_load) begin
        if (xfer) begin
          words_reg   <= words_reg + 1'b1;
          timeout_reg <= '0;
        end else if (starve) begin
          timeout_reg <= timeout_reg + 1'b1;
        end
      end
    end
  end

  assign bs_ready      = ready;
  assign prog_clk_en   = shift_en;
  assign ccff_head_pad = shift_en & sh_lsb;
  assign config_done   = (state_reg == ST_DONE);
  assign busy          = in_load;
  assign error         = (state_reg == ST_ERROR);
  assign bit_count     = bit_count_reg;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: expected chain bits are queued when words
// are issued, and a monitor compares them whenever prog_clk_en is high.
module tb_ccff_loader;

  localparam int CHAIN_LEN = 20;
  localparam int WORD_W    = 8;
  localparam int TIMEOUT   = 4;
  localparam int BC_W      = $clog2(CHAIN_LEN + 1);

  logic              clk_pad    = 1'b0;
  logic              pReset_pad = 1'b1;
  logic              start      = 1'b0;
  logic              abort      = 1'b0;
  logic              bs_valid   = 1'b0;
  logic [WORD_W-1:0] bs_data    = '0;
  logic              bs_ready, ccff_head_pad, prog_clk_en;
  logic              config_done, busy, error;
  logic [BC_W-1:0]   bit_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int xfer_cyc = 0;
  bit exp_q[$];
  int shift_log[$];

  ccff_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_pad       (clk_pad),
    .pReset_pad    (pReset_pad),
    .start         (start),
    .abort         (abort),
    .bs_data       (bs_data),
    .bs_valid      (bs_valid),
    .bs_ready      (bs_ready),
    .ccff_head_pad (ccff_head_pad),
    .prog_clk_en   (prog_clk_en),
    .config_done   (config_done),
    .busy          (busy),
    .error         (error),
    .bit_count     (bit_count)
  );

  always #5 clk_pad = ~clk_pad;

  always @(posedge clk_pad) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every shift cycle must carry the next queued bit.
  always @(negedge clk_pad) begin
    if (prog_clk_en === 1'b1) begin
      shift_log.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_shift", 32'd1, 32'd0);
      else                   chk("head_bit", {31'd0, ccff_head_pad}, {31'd0, exp_q.pop_front()});
    end else begin
      chk("head_idle", {31'd0, ccff_head_pad}, 32'd0);
    end
  end

  task automatic push_expect(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(bits[i]);
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [WORD_W-1:0] w, input int pre_idle);
    int k;
    repeat (pre_idle) @(posedge clk_pad);
    #1;
    bs_data  = w;
    bs_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk_pad);
      k++;
    end while (bs_ready !== 1'b1 && k < 100);
    chk("handshake", {31'd0, bs_ready}, 32'd1);
    xfer_cyc = cyc;
    $display("xfer word 0x%h at cyc %0d", w, cyc);
    @(posedge clk_pad);
    #1;
    bs_valid = 1'b0;
  endtask

  task automatic do_start;
    @(posedge clk_pad);
    #1;
    start = 1'b1;
    @(posedge clk_pad);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_flag(input bit want_err, output int at_cyc);
    int k;
    k = 0;
    do begin
      @(negedge clk_pad);
      k++;
    end while (((want_err ? error : config_done) !== 1'b1) && k < 200);
    at_cyc = cyc;
    chk(want_err ? "error_seen" : "done_seen", {31'd0, (want_err ? error : config_done)}, 32'd1);
  endtask

  task automatic wait_bits(input int n);
    int k;
    k = 0;
    do begin
      @(negedge clk_pad);
      k++;
    end while (bit_count !== BC_W'(n) && k < 100);
    chk("reach_bits", {27'd0, bit_count}, n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, bs_ready},      32'd0);
    chk({tag, "_head"},  {31'd0, ccff_head_pad}, 32'd0);
    chk({tag, "_pclk"},  {31'd0, prog_clk_en},   32'd0);
    chk({tag, "_done"},  {31'd0, config_done},   32'd0);
    chk({tag, "_busy"},  {31'd0, busy},          32'd0);
    chk({tag, "_error"}, {31'd0, error},         32'd0);
    chk({tag, "_bits"},  {27'd0, bit_count},     32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, x1;

    // Reset state.
    #2;
    chk_all_zero("reset");
    @(negedge clk_pad);
    pReset_pad = 1'b0;

    // Back-to-back load: 0xA5,0x3C,0x0F -> first 20 bits LSB first.
    shift_log.delete();
    push_expect(32'h000F3CA5, 20);
    do_start;
    chk("a_busy", {31'd0, busy}, 32'd1);
    send_word(8'hA5, 0);
    x1 = xfer_cyc;
    send_word(8'h3C, 0);
    send_word(8'h0F, 0);
    chk("a_ready_after3", {31'd0, bs_ready}, 32'd0);
    wait_flag(1'b0, t);
    chk("a_done_cycle", t, x1 + 21);
    chk("a_nshift", shift_log.size(), 20);
    chk("a_first_shift", shift_log[0], x1 + 1);
    chk("a_contiguous", shift_log[19] - shift_log[0], 19);
    chk("a_bits", {27'd0, bit_count}, 32'd20);
    chk("a_busy_done", {31'd0, busy}, 32'd0);
    chk("a_ready_done", {31'd0, bs_ready}, 32'd0);
    chk("a_queue", exp_q.size(), 0);
    repeat (3) @(negedge clk_pad);
    chk("a_done_hold", {31'd0, config_done}, 32'd1);
    chk("a_bits_hold", {27'd0, bit_count}, 32'd20);

    // Start in DONE, then a starved stream with 3-cycle gaps.
    do_start;
    @(negedge clk_pad);
    chk("f_done_clr", {31'd0, config_done}, 32'd0);
    chk("f_bits_clr", {27'd0, bit_count}, 32'd0);
    chk("f_busy", {31'd0, busy}, 32'd1);
    @(posedge clk_pad);
    shift_log.delete();
    push_expect(32'h000F3CA5, 20);
    send_word(8'hA5, 0);
    send_word(8'h3C, 10);
    send_word(8'h0F, 10);
    wait_flag(1'b0, t);
    chk("b_nshift", shift_log.size(), 20);
    chk("b_word1_run", shift_log[7] - shift_log[0], 7);
    chk("b_gap1", shift_log[8] - shift_log[7], 4);
    chk("b_gap2", shift_log[16] - shift_log[15], 4);
    chk("b_error", {31'd0, error}, 32'd0);
    chk("b_bits", {27'd0, bit_count}, 32'd20);
    chk("b_queue", exp_q.size(), 0);

    // Single word then starvation -> ERROR 4 cycles after buffer empties.
    do_start;
    push_expect(32'h0000005A, 8);
    send_word(8'h5A, 0);
    x1 = xfer_cyc;
    wait_flag(1'b1, t);
    chk("c_error_cycle", t, x1 + 13);
    chk("c_bits", {27'd0, bit_count}, 32'd8);
    chk("c_busy", {31'd0, busy}, 32'd0);
    chk("c_done", {31'd0, config_done}, 32'd0);
    chk("c_queue", exp_q.size(), 0);
    repeat (2) @(negedge clk_pad);
    chk("c_error_hold", {31'd0, error}, 32'd1);

    // Abort together with start at bit_count=10.
    do_start;
    chk("d_error_clr", {31'd0, error}, 32'd0);
    push_expect(32'h0000C396, 16);
    send_word(8'h96, 0);
    send_word(8'hC3, 0);
    wait_bits(10);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk_pad);
    #1;
    abort = 1'b0;
    start = 1'b0;
    exp_q.delete();
    chk("d_busy", {31'd0, busy}, 32'd0);
    chk("d_pclk", {31'd0, prog_clk_en}, 32'd0);
    chk("d_done", {31'd0, config_done}, 32'd0);
    chk("d_error", {31'd0, error}, 32'd0);
    repeat (3) @(negedge clk_pad);
    chk("d_stay_idle", {31'd0, busy}, 32'd0);

    // Reset pulse at bit_count=5, then a fresh full load.
    do_start;
    push_expect(32'h000000A5, 8);
    send_word(8'hA5, 0);
    wait_bits(5);
    #1;
    pReset_pad = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    exp_q.delete();
    @(negedge clk_pad);
    pReset_pad = 1'b0;
    repeat (4) @(negedge clk_pad);
    chk("e_idle_busy", {31'd0, busy}, 32'd0);
    chk("e_idle_bits", {27'd0, bit_count}, 32'd0);
    push_expect(32'h000F3CA5, 20);
    do_start;
    chk("e_bits_start", {27'd0, bit_count}, 32'd0);
    chk("e_busy", {31'd0, busy}, 32'd1);
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    send_word(8'h0F, 0);
    wait_flag(1'b0, t);
    chk("e_bits", {27'd0, bit_count}, 32'd20);
    chk("e_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 64: configuration-chain length in bits, minimum 1.
REQ-002 Parameter WORD_W, default 8: bitstream word width, minimum 1.
REQ-003 Parameter TIMEOUT, default 255: maximum consecutive starved cycles in LOAD before error, minimum 1.
REQ-004 Port clk_pad, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port pReset_pad, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: begin a load; sampled in IDLE, DONE, ERROR.
REQ-007 Port abort, input, 1: return to IDLE from any state.
REQ-008 Port bs_data, input, WORD_W: bitstream word, LSB shifted first.
REQ-009 Port bs_valid, input, 1: bs_data valid.
REQ-010 Port bs_ready, output, 1: loader accepts a word; transfer occurs when bs_valid and bs_ready are both 1.
REQ-011 Port ccff_head_pad, output, 1: serial configuration bit to the chain head.
REQ-012 Port prog_clk_en, output, 1: 1 in exactly the cycles where ccff_head_pad carries a new chain bit (drives prog_clk gating).
REQ-013 Port config_done, output, 1: chain fully loaded.
REQ-014 Port busy, output, 1: 1 in LOAD.
REQ-015 Port error, output, 1: starvation timeout occurred.
REQ-016 Port bit_count, output, $clog2(CHAIN_LEN+1): bits shifted so far in the current load.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, DONE, ERROR.
REQ-018 IDLE->LOAD, and DONE/ERROR->LOAD, SHALL occur on the cycle after start=1 and abort=0; the transition clears bit_count, the word buffer and the timeout counter.
REQ-019 abort=1 SHALL force IDLE on the next cycle from any state, overriding start, and clear config_done and error.
REQ-020 start while in LOAD SHALL be ignored.
REQ-021 The word buffer SHALL hold 0..WORD_W unshifted bits; in LOAD with a non-empty buffer, one bit SHALL be shifted per cycle: ccff_head_pad=buffer LSB, prog_clk_en=1, bit_count increments.
REQ-022 bs_ready SHALL be 1 in LOAD when the buffer is empty or holds exactly one bit being shifted that cycle, and words accepted < ceil(CHAIN_LEN/WORD_W); else 0.
REQ-023 A word accepted in cycle t SHALL have its bit 0 on ccff_head_pad in cycle t+1; continuous bs_valid SHALL yield prog_clk_en=1 every cycle with no bubbles.
REQ-024 When the shift making bit_count=CHAIN_LEN occurs in cycle t, the FSM SHALL be in DONE in cycle t+1; leftover bits of a partial final word are discarded.
REQ-025 Outside shift cycles prog_clk_en SHALL be 0 and ccff_head_pad SHALL hold 0.
REQ-026 In LOAD, each cycle with an empty buffer and no transfer SHALL increment the timeout counter; any transfer clears it; reaching TIMEOUT SHALL move to ERROR next cycle.
REQ-027 config_done SHALL be 1 exactly in DONE; error SHALL be 1 exactly in ERROR; both hold until start or abort.
REQ-028 bit_count SHALL saturate at CHAIN_LEN and hold its value in DONE and ERROR.

Reset
REQ-029 Asserting pReset_pad SHALL immediately force IDLE, empty buffer, and bit_count=0, bs_ready=0, ccff_head_pad=0, prog_clk_en=0, config_done=0, busy=0, error=0.
REQ-030 Reset mid-LOAD SHALL abandon the load; no further shifts occur until a new start after reset release.

Structure
REQ-031 A shared package ccff_pkg SHALL hold the state enum type and the width helper for bit_count.
REQ-032 The word buffer/shifter SHALL be a sub-module ccff_word_shifter (load, shift, count, LSB output); the FSM, timeout and counters stay in ccff_loader.

Verification (CHAIN_LEN=20, WORD_W=8, TIMEOUT=4)
REQ-033 start, then 3 words 0xA5,0x3C,0x0F back-to-back -> 20 consecutive prog_clk_en cycles, head bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0,1,1,1,1; config_done=1 on cycle 21 after the first transfer; bs_ready=0 after 3 words.
REQ-034 bs_valid deasserted 3 cycles between words -> prog_clk_en gaps of 3 cycles, error=0, final bit_count=20.
REQ-035 start, 1 word, then no valid -> error=1 four cycles after the buffer empties; bit_count=8.
REQ-036 abort at bit_count=10 together with start -> IDLE next cycle, busy=0, prog_clk_en=0, config_done=0.
REQ-037 pReset_pad pulsed at bit_count=5 -> all outputs 0 immediately; new start reloads from bit_count=0.
REQ-038 start in DONE -> LOAD next cycle, config_done=0, bit_count=0.
